// File: rtl/board_serializer_pkg.sv
// Shared board-state definitions: card layout, pile geometry, stream tag codes and pile ids.
// Card = {rank[3:0], suit[1:0], visible}; rank 0 marks an empty slot, slot 0 is the pile bottom.
package board_serializer_pkg;

  localparam int CARD_W        = 7;
  localparam int STOCK_DEPTH   = 24;
  localparam int TABLEAU_DEPTH = 19;
  localparam int NUM_TABLEAU   = 7;
  localparam int FOUND_SLOTS   = 4;

  localparam int STOCK_W   = CARD_W * STOCK_DEPTH;
  localparam int TABLEAU_W = CARD_W * TABLEAU_DEPTH;
  localparam int FOUND_W   = CARD_W * FOUND_SLOTS;

  typedef logic [CARD_W-1:0] card_t;
  typedef logic [1:0]        tag_t;

  localparam tag_t TAG_PILE   = 2'b00;
  localparam tag_t TAG_CARD   = 2'b01;
  localparam tag_t TAG_HIDDEN = 2'b10;
  localparam tag_t TAG_END    = 2'b11;

  localparam logic [3:0] PILE_STOCK = 4'd0;
  localparam logic [3:0] PILE_TALON = 4'd1;
  localparam logic [3:0] PILE_TAB1  = 4'd2;
  localparam logic [3:0] PILE_TAB7  = 4'd8;
  localparam logic [3:0] PILE_FOUND = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CARDS,
    S_ADV,
    S_END
  } state_t;

  function automatic logic [3:0] card_rank(card_t c);
    return c[6:3];
  endfunction

  function automatic logic [1:0] card_suit(card_t c);
    return c[2:1];
  endfunction

  function automatic logic card_visible(card_t c);
    return c[0];
  endfunction

endpackage

// File: rtl/board_serializer_if.sv
// Tagged board stream: one {tag, data} item per valid/ready transfer.
// Data is held stable by the producer while valid is high and ready is low.
interface board_serializer_if;
  import board_serializer_pkg::*;

  logic  out_valid;
  logic  out_ready;
  tag_t  out_tag;
  card_t out_data;

  modport master (output out_valid, out_tag, out_data, input out_ready);
  modport slave  (input out_valid, out_tag, out_data, output out_ready);

endinterface

// File: rtl/board_serializer_pile_slot_mux.sv
// Combinational pick of one card from the snapshot by pile id and slot, plus that pile's depth.
// Slots at or beyond the depth read as an empty card, so callers may probe one past the top.
module pile_slot_mux
  import board_serializer_pkg::*;
(
  input  logic [STOCK_W-1:0]                    stock,
  input  logic [STOCK_W-1:0]                    talon,
  input  logic [NUM_TABLEAU-1:0][TABLEAU_W-1:0] tableau,
  input  logic [FOUND_W-1:0]                    foundation,
  input  logic [3:0]                            pile_id,
  input  logic [4:0]                            slot,
  output card_t                                 card,
  output logic [4:0]                            depth
);

  logic [2:0] tab_idx;

  always_comb begin
    card    = '0;
    depth   = '0;
    tab_idx = 3'(pile_id - PILE_TAB1);
    case (pile_id)
      PILE_STOCK: begin
        depth = 5'(STOCK_DEPTH);
        if (slot < 5'(STOCK_DEPTH)) card = stock[slot*CARD_W +: CARD_W];
      end
      PILE_TALON: begin
        depth = 5'(STOCK_DEPTH);
        if (slot < 5'(STOCK_DEPTH)) card = talon[slot*CARD_W +: CARD_W];
      end
      PILE_FOUND: begin
        depth = 5'(FOUND_SLOTS);
        if (slot < 5'(FOUND_SLOTS)) card = foundation[slot*CARD_W +: CARD_W];
      end
      default: begin
        if (pile_id <= PILE_TAB7) begin
          depth = 5'(TABLEAU_DEPTH);
          if (slot < 5'(TABLEAU_DEPTH)) card = tableau[tab_idx][slot*CARD_W +: CARD_W];
        end
      end
    endcase
  end

endmodule

// File: rtl/board_serializer.sv
// Snapshots the board on start and streams PILE/CARD/HIDDEN/END items, one per cycle, registered.
// First header one cycle after start; each pile end costs one idle cycle; ready low stalls indefinitely.
module board_serializer
  import board_serializer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [STOCK_W-1:0]   stock_pile,
  input  logic [STOCK_W-1:0]   talon_pile,
  input  logic [TABLEAU_W-1:0] tableau1,
  input  logic [TABLEAU_W-1:0] tableau2,
  input  logic [TABLEAU_W-1:0] tableau3,
  input  logic [TABLEAU_W-1:0] tableau4,
  input  logic [TABLEAU_W-1:0] tableau5,
  input  logic [TABLEAU_W-1:0] tableau6,
  input  logic [TABLEAU_W-1:0] tableau7,
  input  logic [FOUND_W-1:0]   foundation_cards,
  board_serializer_if.master   strm,
  output logic                 busy,
  output logic                 done
);

  logic [STOCK_W-1:0]                    snap_stock, snap_talon;
  logic [NUM_TABLEAU-1:0][TABLEAU_W-1:0] snap_tab;
  logic [FOUND_W-1:0]                    snap_found;

  state_t     state_q, state_d;
  logic [3:0] pile_q, pile_d, nxt_pile;
  logic [4:0] slot_q, slot_d, sel_slot, pile_depth;
  card_t      csum_q, csum_d, dat_q, dat_d, sel_card, item_dat;
  tag_t       tag_q, tag_d, item_tag;
  logic       vld_q, vld_d, busy_q, busy_d, done_q, done_d;
  logic       capture, xfer, is_found, item_ok;

  pile_slot_mux u_mux (
    .stock      (snap_stock),
    .talon      (snap_talon),
    .tableau    (snap_tab),
    .foundation (snap_found),
    .pile_id    (pile_q),
    .slot       (sel_slot),
    .card       (sel_card),
    .depth      (pile_depth)
  );

  // Look one slot ahead so the next item is ready in the same edge as the current transfer.
  assign sel_slot = (state_q == S_HDR) ? 5'd0 : 5'(slot_q + 5'd1);
  assign is_found = (pile_q == PILE_FOUND);
  assign item_ok  = (sel_slot < pile_depth) && (is_found || card_rank(sel_card) != 4'd0);
  assign item_tag = (is_found || card_visible(sel_card)) ? TAG_CARD : TAG_HIDDEN;
  assign item_dat = (item_tag == TAG_CARD && card_rank(sel_card) != 4'd0) ? sel_card : '0;
  assign nxt_pile = 4'(pile_q + 4'd1);
  assign xfer     = vld_q & strm.out_ready;

  always_comb begin
    state_d = state_q;
    pile_d  = pile_q;
    slot_d  = slot_q;
    csum_d  = csum_q;
    vld_d   = vld_q;
    tag_d   = tag_q;
    dat_d   = dat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          pile_d  = PILE_STOCK;
          slot_d  = '0;
          csum_d  = '0;
          busy_d  = 1'b1;
          vld_d   = 1'b1;
          tag_d   = TAG_PILE;
          dat_d   = '0;
          state_d = S_HDR;
        end
      end
      S_HDR, S_CARDS: begin
        if (xfer) begin
          if (state_q == S_CARDS && tag_q == TAG_CARD) csum_d = csum_q ^ dat_q;
          slot_d  = item_ok ? sel_slot : 5'd0;
          vld_d   = item_ok;
          tag_d   = item_tag;
          dat_d   = item_dat;
          state_d = item_ok ? S_CARDS : S_ADV;
        end
      end
      S_ADV: begin
        vld_d = 1'b1;
        if (is_found) begin
          tag_d   = TAG_END;
          dat_d   = csum_q;
          state_d = S_END;
        end else begin
          pile_d  = nxt_pile;
          tag_d   = TAG_PILE;
          dat_d   = {3'b000, nxt_pile};
          state_d = S_HDR;
        end
      end
      S_END: begin
        if (xfer) begin
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pile_q  <= '0;
      slot_q  <= '0;
      csum_q  <= '0;
      vld_q   <= 1'b0;
      tag_q   <= TAG_PILE;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pile_q  <= pile_d;
      slot_q  <= slot_d;
      csum_q  <= csum_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_stock <= '0;
      snap_talon <= '0;
      snap_tab   <= '0;
      snap_found <= '0;
    end else if (capture) begin
      snap_stock <= stock_pile;
      snap_talon <= talon_pile;
      snap_tab   <= {tableau7, tableau6, tableau5, tableau4, tableau3, tableau2, tableau1};
      snap_found <= foundation_cards;
    end
  end

  assign strm.out_valid = vld_q;
  assign strm.out_tag   = tag_q;
  assign strm.out_data  = dat_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
